// File: rtl/dds_demod_pkg.sv
// Shared widths, modulation codes and FSM state encoding for the DDS demodulator.
package dds_demod_pkg;

    localparam int ACC_W    = 28;
    localparam int SAMPLE_W = 12;

    localparam logic [1:0] MOD_ASK  = 2'b00;
    localparam logic [1:0] MOD_FSK  = 2'b01;
    localparam logic [1:0] MOD_BPSK = 2'b10;
    localparam logic [1:0] MOD_LFSR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCUM  = 2'b01,
        ST_DECIDE = 2'b10
    } state_t;

endpackage

// File: rtl/demod_accumulator.sv
// Per-sample ASK magnitude / BPSK correlation term feeding a saturating signed accumulator.
module demod_accumulator
    import dds_demod_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       enable,
    input  logic                       mode_bpsk,
    input  logic signed [SAMPLE_W-1:0] mod_signal,
    input  logic signed [SAMPLE_W-1:0] ref_sin,
    output logic signed [ACC_W-1:0]    sum
);

    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]    ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]    ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [2*SAMPLE_W-1:0] product;
    logic        [SAMPLE_W-2:0]   magnitude;
    logic signed [ACC_W-1:0]      term;
    logic signed [ACC_W-1:0]      base;
    logic signed [ACC_W:0]        wide;
    logic signed [ACC_W-1:0]      next_sum;

    always_comb begin
        product = (2*SAMPLE_W)'(mod_signal) * (2*SAMPLE_W)'(ref_sin);

        // The most negative sample has no positive twin, so its magnitude clips to full scale.
        if (mod_signal == SAMPLE_MIN) begin
            magnitude = '1;
        end else if (mod_signal[SAMPLE_W-1]) begin
            magnitude = ~mod_signal[SAMPLE_W-2:0] + 1'b1;
        end else begin
            magnitude = mod_signal[SAMPLE_W-2:0];
        end

        if (mode_bpsk) begin
            term = {{(ACC_W-2*SAMPLE_W){product[2*SAMPLE_W-1]}}, product};
        end else begin
            term = {{(ACC_W-SAMPLE_W+1){1'b0}}, magnitude};
        end

        base = clear ? '0 : sum;
        wide = {base[ACC_W-1], base} + {term[ACC_W-1], term};

        // Clip rather than wrap so a long symbol can never flip the sign of the result.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            next_sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            next_sum = wide[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (enable) begin
            sum <= next_sum;
        end else if (clear) begin
            sum <= '0;
        end
    end

endmodule

// File: rtl/dds_demod.sv
// Symbol-integrating ASK/BPSK demodulator recovering one LFSR bit per symbol.
// Defining DDS_DEMOD_STATS_EN adds the sym_count / abort_count statistics outputs.
module dds_demod
    import dds_demod_pkg::*;
#(
    parameter int               SAMPLES_PER_SYMBOL = 16,
    parameter logic [ACC_W-1:0] ASK_THRESHOLD      = 28'd4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [SAMPLE_W-1:0] mod_signal,
    input  logic [SAMPLE_W-1:0] ref_sin,
    input  logic                symbol_start,
    input  logic [1:0]          modulation_sel,
    output logic                bit_out,
    output logic                bit_valid,
    output logic                busy
`ifdef DDS_DEMOD_STATS_EN
    ,
    output logic [15:0]         sym_count,
    output logic [7:0]          abort_count
`endif
);

    localparam logic [8:0] SPS = 9'(SAMPLES_PER_SYMBOL);

    state_t           state;
    logic [1:0]       sel_q;
    logic [8:0]       count;
    logic [ACC_W-1:0] sum;
    logic             accept;
    logic             counting;
    logic             acc_en;
    logic             acc_bpsk;
    logic             decision;

    // Only ASK and BPSK symbols are demodulated; other selects never start a symbol.
    assign accept   = symbol_start && (modulation_sel == MOD_ASK || modulation_sel == MOD_BPSK);
    assign counting = (state == ST_ACCUM) && !symbol_start && (count != SPS);
    assign acc_en   = sample_en && (accept || counting);
    assign acc_bpsk = accept ? (modulation_sel == MOD_BPSK) : (sel_q == MOD_BPSK);
    assign decision = (sel_q == MOD_BPSK) ? sum[ACC_W-1] : (sum <= ASK_THRESHOLD);

    demod_accumulator u_acc (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .enable     (acc_en),
        .mode_bpsk  (acc_bpsk),
        .mod_signal (mod_signal),
        .ref_sin    (ref_sin),
        .sum        (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel_q     <= MOD_ASK;
            count     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sel_q <= modulation_sel;
                        count <= sample_en ? 9'd1 : 9'd0;
                        state <= ST_ACCUM;
                        busy  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (symbol_start) begin
                        if (accept) begin
                            sel_q <= modulation_sel;
                            count <= sample_en ? 9'd1 : 9'd0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (count == SPS) begin
                        state <= ST_DECIDE;
                    end else if (sample_en) begin
                        count <= count + 9'd1;
                    end
                end
                ST_DECIDE: begin
                    bit_out   <= decision;
                    bit_valid <= 1'b1;
                    // A boundary landing on the decide cycle starts the next symbol immediately.
                    if (accept) begin
                        sel_q <= modulation_sel;
                        count <= sample_en ? 9'd1 : 9'd0;
                        state <= ST_ACCUM;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DDS_DEMOD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_count   <= '0;
            abort_count <= '0;
        end else begin
            if (state == ST_DECIDE) begin
                sym_count <= sym_count + 16'd1;
            end
            if (state == ST_ACCUM && symbol_start) begin
                abort_count <= abort_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dds_demod.sv
// Randomised bench for dds_demod: arithmetic reference model, expected-bit queue and boundary scenarios.
module tb_dds_demod;
    import dds_demod_pkg::*;

    localparam int     SPS     = 16;
    localparam int     BIG_SPS = 256;
    localparam int     THRESH  = 4096;
    localparam longint ACC_MAX = 134217727;
    localparam longint ACC_MIN = -134217728;

    logic        clk;
    logic        reset;
    logic        sample_en;
    logic [11:0] mod_signal;
    logic [11:0] ref_sin;
    logic        symbol_start;
    logic [1:0]  modulation_sel;
    logic        bit_out;
    logic        bit_valid;
    logic        busy;

    logic        b_sample_en;
    logic [11:0] b_mod_signal;
    logic [11:0] b_ref_sin;
    logic        b_symbol_start;
    logic [1:0]  b_modulation_sel;
    logic        b_bit_out;
    logic        b_bit_valid;
    logic        b_busy;

`ifdef DDS_DEMOD_STATS_EN
    logic [15:0] sym_count;
    logic [7:0]  abort_count;
    logic [15:0] b_sym_count;
    logic [7:0]  b_abort_count;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_sym = 0;
    int          exp_abort = 0;
    int          ms_a[$];
    int          rs_a[$];
    logic [0:0]  exp_q[$];

    dds_demod #(.SAMPLES_PER_SYMBOL(SPS), .ASK_THRESHOLD(28'd4096)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_en      (sample_en),
        .mod_signal     (mod_signal),
        .ref_sin        (ref_sin),
        .symbol_start   (symbol_start),
        .modulation_sel (modulation_sel),
        .bit_out        (bit_out),
        .bit_valid      (bit_valid),
        .busy           (busy)
`ifdef DDS_DEMOD_STATS_EN
        ,
        .sym_count      (sym_count),
        .abort_count    (abort_count)
`endif
    );

    dds_demod #(.SAMPLES_PER_SYMBOL(BIG_SPS), .ASK_THRESHOLD(28'd4096)) dut_big (
        .clk            (clk),
        .reset          (reset),
        .sample_en      (b_sample_en),
        .mod_signal     (b_mod_signal),
        .ref_sin        (b_ref_sin),
        .symbol_start   (b_symbol_start),
        .modulation_sel (b_modulation_sel),
        .bit_out        (b_bit_out),
        .bit_valid      (b_bit_valid),
        .busy           (b_busy)
`ifdef DDS_DEMOD_STATS_EN
        ,
        .sym_count      (b_sym_count),
        .abort_count    (b_abort_count)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integrate the symbol with plain integer arithmetic, clip to the 28-bit range, decide.
    function automatic logic model_bit(input logic [1:0] sel, input int n);
        longint acc = 0;
        for (int i = 0; i < n; i++) begin
            if (sel == MOD_BPSK) begin
                acc += longint'(ms_a[i]) * longint'(rs_a[i]);
            end else if (ms_a[i] == -2048) begin
                acc += 2047;
            end else begin
                acc += (ms_a[i] < 0) ? -ms_a[i] : ms_a[i];
            end
            if (acc > ACC_MAX) acc = ACC_MAX;
            if (acc < ACC_MIN) acc = ACC_MIN;
        end
        return (sel == MOD_BPSK) ? (acc < 0) : (acc <= THRESH);
    endfunction

    task automatic step(input logic ss, input logic se, input int ms, input int rs, input logic [1:0] sel);
        symbol_start   = ss;
        sample_en      = se;
        mod_signal     = 12'(ms);
        ref_sin        = 12'(rs);
        modulation_sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0, MOD_ASK);
    endtask

    // kind 0: ms = -rs, rs = +/-a; kind 1: ms = +/-a; kind 2: ms uniform in [-a, a] (a = 2048 is full scale)
    task automatic fill(input int kind, input int a, input int n);
        int r;
        ms_a.delete();
        rs_a.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 1) ? a : -a;
            case (kind)
                0: begin rs_a.push_back(r); ms_a.push_back(-r); end
                1: begin rs_a.push_back(int'($urandom_range(0, 4095)) - 2048); ms_a.push_back(r); end
                default: begin
                    rs_a.push_back(int'($urandom_range(0, 4095)) - 2048);
                    if (a >= 2048) ms_a.push_back(int'($urandom_range(0, 4095)) - 2048);
                    else ms_a.push_back(int'($urandom_range(0, 2 * a)) - a);
                end
            endcase
        end
    endtask

    task automatic run_symbol(input logic [1:0] sel, input logic [1:0] sel_mid, input bit keep_open);
        logic eb;
        int   gaps;
        eb = model_bit(sel, SPS);
        exp_q.push_back(eb);
        exp_sym++;
        for (int i = 0; i < SPS; i++) begin
            if (i > 0) begin
                gaps = $urandom_range(0, 2);
                repeat (gaps) step(1'b0, 1'b0, int'($urandom_range(0, 4095)) - 2048, 5, sel_mid);
            end
            step(i == 0, 1'b1, ms_a[i], rs_a[i], (i == 0) ? sel : sel_mid);
        end
        step(1'b0, 1'b0, 0, 0, sel_mid);
        check("decide_no_valid", bit_valid, 0);
        check("decide_busy", busy, 1);
        if (!keep_open) begin
            step(1'b0, 1'b0, 0, 0, sel_mid);
            check("latency_valid", bit_valid, 1);
            check("after_decide_busy", busy, 0);
        end
    endtask

    task automatic big_symbol();
        logic eb;
        eb = model_bit(MOD_BPSK, BIG_SPS);
        for (int i = 0; i < BIG_SPS; i++) begin
            b_symbol_start   = (i == 0);
            b_sample_en      = 1'b1;
            b_mod_signal     = 12'(ms_a[i]);
            b_ref_sin        = 12'(rs_a[i]);
            b_modulation_sel = (i == 0) ? MOD_BPSK : MOD_ASK;
            idle(1);
        end
        b_symbol_start = 1'b0;
        b_sample_en    = 1'b0;
        idle(1);
        check("big_decide_no_valid", b_bit_valid, 0);
        idle(1);
        check("big_latency_valid", b_bit_valid, 1);
        check("big_bit_out", b_bit_out, eb);
    endtask

    // Scoreboard: every bit_valid pulse consumes one expected decision.
    always @(posedge clk) begin
        logic [0:0] e;
        #1;
        if (bit_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_bit_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("bit_out", bit_out, e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        b_symbol_start = 1'b0; b_sample_en = 1'b0; b_mod_signal = '0; b_ref_sin = '0; b_modulation_sel = MOD_ASK;
        idle(3);
        check("reset_bit_out", bit_out, 0);
        check("reset_bit_valid", bit_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_big_busy", b_busy, 0);
`ifdef DDS_DEMOD_STATS_EN
        check("reset_sym_count", sym_count, 0);
        check("reset_abort_count", abort_count, 0);
`endif
        reset = 1'b0;
        idle(2);

        // BPSK with an inverted carrier
        fill(0, 1000, SPS);
        run_symbol(MOD_BPSK, MOD_BPSK, 1'b0);
        idle(4);
        check("hold_bit_out", bit_out, 1);
        check("hold_bit_valid", bit_valid, 0);

        // Reset partway through a symbol, then unsupported selects must stay idle
        fill(0, 1000, SPS);
        step(1'b1, 1'b1, ms_a[0], rs_a[0], MOD_BPSK);
        for (int i = 1; i < 5; i++) step(1'b0, 1'b1, ms_a[i], rs_a[i], MOD_BPSK);
        reset = 1'b1;
        step(1'b1, 1'b1, 100, 100, MOD_BPSK);
        reset = 1'b0;
        exp_sym = 0;
        exp_abort = 0;
        check("midreset_bit_out", bit_out, 0);
        check("midreset_bit_valid", bit_valid, 0);
        check("midreset_busy", busy, 0);
        step(1'b1, 1'b0, 0, 0, MOD_FSK);
        check("fsk_idle_busy", busy, 0);
        step(1'b1, 1'b1, 7, 7, MOD_LFSR);
        check("lfsr_idle_busy", busy, 0);
        idle(SPS + 4);
        check("unsupported_busy", busy, 0);

        // ASK: silence is a 1, strong carrier is a 0
        fill(1, 0, SPS);
        run_symbol(MOD_ASK, MOD_ASK, 1'b0);
        fill(1, 1000, SPS);
        run_symbol(MOD_ASK, MOD_ASK, 1'b0);

        // Select changed to ASK mid-symbol; latched BPSK still decides
        fill(0, 1000, SPS);
        run_symbol(MOD_BPSK, MOD_ASK, 1'b0);

        // ASK threshold boundary: sum 4096 decides 1, 4097 decides 0
        ms_a.delete(); rs_a.delete();
        for (int i = 0; i < SPS; i++) begin ms_a.push_back((i % 2 == 0) ? 256 : -256); rs_a.push_back(3); end
        run_symbol(MOD_ASK, MOD_ASK, 1'b0);
        ms_a[0] = 257;
        run_symbol(MOD_ASK, MOD_ASK, 1'b0);

        // Full-scale negative sample magnitude clips to 2047
        ms_a.delete(); rs_a.delete();
        for (int i = 0; i < SPS; i++) begin ms_a.push_back(i < 2 ? -2048 : (i == 2 ? 2 : 0)); rs_a.push_back(0); end
        run_symbol(MOD_ASK, MOD_ASK, 1'b0);
        for (int i = 0; i < SPS; i++) ms_a[i] = (i < 3) ? -2048 : 0;
        run_symbol(MOD_ASK, MOD_ASK, 1'b0);

        // Abort after sample 7, then exactly one decision for the restarted symbol
        fill(0, 1000, SPS);
        step(1'b1, 1'b1, ms_a[0], rs_a[0], MOD_BPSK);
        for (int i = 1; i < 7; i++) step(1'b0, 1'b1, ms_a[i], rs_a[i], MOD_BPSK);
        exp_abort++;
        fill(2, 2048, SPS);
        run_symbol(MOD_ASK, MOD_ASK, 1'b0);
        idle(3);
        check("abort_pending", exp_q.size(), 0);
`ifdef DDS_DEMOD_STATS_EN
        check("abort_count", abort_count, 8'(exp_abort));
`endif

        // Boundary arriving during the decide cycle goes straight back to integration
        fill(0, 1000, SPS);
        run_symbol(MOD_BPSK, MOD_BPSK, 1'b1);
        fill(1, 1000, SPS);
        run_symbol(MOD_ASK, MOD_BPSK, 1'b0);

        // Random symbols
        for (int s = 0; s < 24; s++) begin
            logic [1:0] sel;
            bit         chain;
            int         scale;
            sel = $urandom_range(0, 1) ? MOD_BPSK : MOD_ASK;
            case ($urandom_range(0, 3))
                0: scale = 100;
                1: scale = 300;
                2: scale = 512;
                default: scale = 2048;
            endcase
            fill(2, (sel == MOD_BPSK) ? 2048 : scale, SPS);
            chain = (s < 23) && ($urandom_range(0, 3) == 0);
            run_symbol(sel, 2'($urandom_range(0, 3)), chain);
            if (!chain) idle($urandom_range(0, 3));
        end
        idle(4);
        check("pending_decisions", exp_q.size(), 0);
`ifdef DDS_DEMOD_STATS_EN
        check("sym_count", sym_count, 16'(exp_sym));
        check("abort_count_final", abort_count, 8'(exp_abort));
`endif

        // 256-sample symbols: inverted carrier, then full-scale products that must clip, not wrap
        ms_a.delete(); rs_a.delete();
        for (int i = 0; i < BIG_SPS; i++) begin rs_a.push_back((i % 3 == 0) ? -1000 : 1000); ms_a.push_back(-rs_a[i]); end
        big_symbol();
        for (int i = 0; i < BIG_SPS; i++) begin ms_a[i] = (i < BIG_SPS - 1) ? -2048 : 0; rs_a[i] = ms_a[i]; end
        big_symbol();
        for (int i = 0; i < BIG_SPS; i++) begin ms_a[i] = -2048; rs_a[i] = -2048; end
        big_symbol();
        idle(3);
        check("big_idle_busy", b_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
